// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, mnemonic codes and encoder state type.
// The decoder and the instruction encoder both import this package.
package mips_pkg;

   // Symbolic mnemonics understood by the control decoder; codes 13-15 are illegal.
   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      SLT  = 4'd4,
      LW   = 4'd5,
      SW   = 4'd6,
      BEQ  = 4'd7,
      BNE  = 4'd8,
      ADDI = 4'd9,
      ANDI = 4'd10,
      ORI  = 4'd11,
      J    = 4'd12
   } mnem_t;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // Load-session controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_t;

   // R-type word: shamt is always zero for the supported set
   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   // I-type word
   function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // J-type word
   function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: mnemonic plus fields -> 32-bit machine word and legality flag.
// Fields a format does not use never reach the output word.
module instr_pack
   import mips_pkg::*;
(
   input  logic [3:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   // Select the format and opcode/funct for the mnemonic; unknown codes give a zero word
   always_comb begin
      word  = 32'd0;
      legal = 1'b1;
      case (mnem)
         ADD:     word = pack_r(rs, rt, rd, FN_ADD);
         SUB:     word = pack_r(rs, rt, rd, FN_SUB);
         AND:     word = pack_r(rs, rt, rd, FN_AND);
         OR:      word = pack_r(rs, rt, rd, FN_OR);
         SLT:     word = pack_r(rs, rt, rd, FN_SLT);
         LW:      word = pack_i(OP_LW,   rs, rt, imm);
         SW:      word = pack_i(OP_SW,   rs, rt, imm);
         BEQ:     word = pack_i(OP_BEQ,  rs, rt, imm);
         BNE:     word = pack_i(OP_BNE,  rs, rt, imm);
         ADDI:    word = pack_i(OP_ADDI, rs, rt, imm);
         ANDI:    word = pack_i(OP_ANDI, rs, rt, imm);
         ORI:     word = pack_i(OP_ORI,  rs, rt, imm);
         J:       word = pack_j(OP_J, target);
         default: begin
            word  = 32'd0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into imem at consecutive word addresses.
// One output register stage: a descriptor accepted in cycle N is written from cycle N+1,
// and the register may reload in the same cycle its previous write completes.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_mnem,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   input  logic          in_last,
   output logic          imem_we,
   input  logic          imem_ready,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_count
);

   enc_state_t    state_r;
   enc_state_t    state_nx_s;
   logic [AW-1:0] addr_r;
   logic [31:0]   wdata_r;
   logic          we_r;
   logic          err_r;
   logic [AW:0]   count_r;
   logic [31:0]   pack_word_s;
   logic          pack_legal_s;
   logic          ready_s;
   logic          accept_s;
   logic          wr_done_s;
   logic          session_start_s;

   instr_pack u_pack (
      .mnem   (in_mnem),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .imm    (in_imm),
      .target (in_target),
      .word   (pack_word_s),
      .legal  (pack_legal_s)
   );

   // Ready whenever the output register is empty or drains this cycle
   assign ready_s         = (state_r == ST_LOAD) && (!we_r || imem_ready);
   assign accept_s        = in_valid && ready_s;
   assign wr_done_s       = we_r && imem_ready;
   assign session_start_s = (state_r == ST_IDLE) && start;

   assign in_ready   = ready_s;
   assign imem_we    = we_r;
   assign imem_addr  = addr_r;
   assign imem_wdata = wdata_r;
   assign err        = err_r;
   assign word_count = count_r;
   assign busy       = (state_r != ST_IDLE);
   assign done       = (state_r == ST_DONE);

   // Session sequencing: start -> load descriptors -> drain last write -> done pulse
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s && in_last) begin
               state_nx_s = ST_FLUSH;
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_FLUSH: begin
            if (!we_r || wr_done_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_FLUSH;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Output word register, address/count counters and sticky illegal-mnemonic flag
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r    <= 1'b0;
         wdata_r <= 32'd0;
         addr_r  <= '0;
         count_r <= '0;
         err_r   <= 1'b0;
      end else begin
         // A fresh legal word takes priority over clearing the strobe of the completed one
         if (accept_s && pack_legal_s) begin
            we_r    <= 1'b1;
            wdata_r <= pack_word_s;
         end else if (wr_done_s) begin
            we_r <= 1'b0;
         end

         // Address wraps silently modulo 2^AW
         if (session_start_s) begin
            addr_r  <= base_addr;
            count_r <= '0;
         end else if (wr_done_s) begin
            addr_r  <= addr_r + AW'(1);
            count_r <= count_r + (AW+1)'(1);
         end

         if (session_start_s) begin
            err_r <= 1'b0;
         end else if (accept_s && !pack_legal_s) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions,
// scored against a transaction-level model (pending-write queue and session phase).
module tb_instr_encoder;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_mnem;
   logic [4:0]    in_rs, in_rt, in_rd;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;
   logic          in_last;
   logic          imem_we;
   logic          imem_ready;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy, done, err;
   logic [AW:0]   word_count;

   instr_encoder #(.AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mnem    (in_mnem),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_imm     (in_imm),
      .in_target  (in_target),
      .in_last    (in_last),
      .imem_we    (imem_we),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: words waiting to be written, session phase (0 idle, 1 load,
   // 2 flush, 3 done), write address, words written, error flag, accepted count
   logic [31:0]   q[$];
   int            ph = 0;
   logic [AW-1:0] m_addr = '0;
   logic [AW:0]   m_cnt = '0;
   logic          m_err = 1'b0;
   int            m_acc = 0;

   // Machine word from the instruction-set tables: {legal, word}
   function automatic logic [32:0] ref_word(input int mn, input int rs, input int rt,
                                            input int rd, input int imm, input int target);
      longint opc [13];
      longint fn [5];
      longint w;
      opc = '{0, 0, 0, 0, 0, 35, 43, 4, 5, 8, 12, 13, 2};
      fn  = '{32, 34, 36, 37, 42};
      if (mn > 12) return {1'b0, 32'd0};
      if (mn < 5)
         w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn[mn];
      else if (mn == 12)
         w = opc[mn] * 67108864 + longint'(target);
      else
         w = opc[mn] * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
      return {1'b1, w[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare DUT against the model before the coming edge, then advance the model across it
   task automatic monitor();
      logic        exp_ready;
      logic [32:0] r;
      int          old;
      if (reset) begin
         q.delete();
         ph = 0; m_addr = '0; m_cnt = '0; m_err = 1'b0;
         return;
      end
      exp_ready = (ph == 1) && (q.size() == 0 || imem_ready);
      chk("we",    64'(imem_we),    64'(q.size() != 0));
      chk("ready", 64'(in_ready),   64'(exp_ready));
      chk("busy",  64'(busy),       64'(ph != 0));
      chk("done",  64'(done),       64'(ph == 3));
      chk("err",   64'(err),        64'(m_err));
      chk("count", 64'(word_count), 64'(m_cnt));
      if (q.size() != 0) begin
         chk("addr",  64'(imem_addr),  64'(m_addr));
         chk("wdata", 64'(imem_wdata), 64'(q[0]));
      end
      old = ph;
      if (q.size() != 0 && imem_ready) begin
         void'(q.pop_front());
         m_addr++;
         m_cnt++;
      end
      if (old == 1) begin
         if (in_valid && exp_ready) begin
            m_acc++;
            r = ref_word(int'(in_mnem), int'(in_rs), int'(in_rt), int'(in_rd),
                         int'(in_imm), int'(in_target));
            if (r[32]) q.push_back(r[31:0]);
            else m_err = 1'b1;
            if (in_last) ph = 2;
         end
      end else if (old == 0) begin
         if (start) begin
            ph = 1; m_addr = base_addr; m_cnt = '0; m_err = 1'b0;
         end
      end else if (old == 2) begin
         if (q.size() == 0) ph = 3;
      end else begin
         ph = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic set_desc(input int mn, input int rs, input int rt, input int rd,
                           input int imm, input int target, input logic last);
      in_valid  = 1'b1;
      in_mnem   = 4'(mn);
      in_rs     = 5'(rs);
      in_rt     = 5'(rt);
      in_rd     = 5'(rd);
      in_imm    = 16'(imm);
      in_target = 26'(target);
      in_last   = last;
   endtask

   task automatic begin_session(input logic [AW-1:0] b);
      base_addr = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      in_valid = 1'b0;
      imem_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("idle_timeout", 64'(busy), 64'd0);
      tick();
   endtask

   task automatic rand_session(input int n);
      int acc0;
      int guard;
      acc0 = m_acc;
      guard = 0;
      begin_session(8'($urandom));
      while ((m_acc - acc0) < n && guard < 600) begin
         set_desc($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535), int'($urandom & 32'h03FF_FFFF),
                  1'b0);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_last    = ((m_acc - acc0) == n - 1);
         imem_ready = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
      end
      chk("rand_accepts", 64'(m_acc - acc0), 64'(n));
      wait_idle();
      chk("rand_phase", 64'(ph), 64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_mnem = 4'd0;
      in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
      in_last = 1'b0; imem_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_we",       64'(imem_we), 64'd0);
      chk("rst_addr",     64'(imem_addr), 64'd0);
      chk("rst_wdata",    64'(imem_wdata), 64'd0);
      chk("rst_busy",     64'(busy), 64'd0);
      chk("rst_done",     64'(done), 64'd0);
      chk("rst_err",      64'(err), 64'd0);
      chk("rst_count",    64'(word_count), 64'd0);

      // Single ADD, one-cycle latency
      begin_session(8'h10);
      set_desc(0, 9, 10, 8, 16'hFFFF, 26'h3FF_FFFF, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("add_we",    64'(imem_we), 64'd1);
      chk("add_addr",  64'(imem_addr), 64'h10);
      chk("add_wdata", 64'(imem_wdata), 64'h012A4020);
      wait_idle();
      chk("add_count", 64'(word_count), 64'd1);

      // Back-to-back stream
      begin_session(8'h20);
      set_desc(5, 29, 8, 31, 4, 26'h155_5555, 1'b0);
      tick();
      chk("lw_wdata", 64'(imem_wdata), 64'h8FA80004);
      set_desc(6, 29, 8, 0, 8, 0, 1'b0);
      tick();
      chk("sw_wdata", 64'(imem_wdata), 64'hAFA80008);
      chk("sw_addr",  64'(imem_addr), 64'h21);
      set_desc(11, 0, 8, 7, 16'h00FF, 0, 1'b0);
      tick();
      chk("ori_wdata", 64'(imem_wdata), 64'h340800FF);
      set_desc(12, 31, 31, 31, 16'hFFFF, 26'h10, 1'b1);
      tick();
      chk("j_wdata", 64'(imem_wdata), 64'h08000010);
      chk("j_addr",  64'(imem_addr), 64'h23);
      wait_idle();
      chk("stream_count", 64'(word_count), 64'd4);

      // Back-pressure while BEQ is pending
      begin_session(8'h30);
      imem_ready = 1'b0;
      set_desc(7, 1, 2, 0, 16'hFFFF, 0, 1'b0);
      tick();
      set_desc(0, 3, 4, 5, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", 64'(in_ready), 64'd0);
         chk("stall_wdata", 64'(imem_wdata), 64'h1022FFFF);
         chk("stall_addr",  64'(imem_addr), 64'h30);
      end
      imem_ready = 1'b1;
      tick();
      chk("unstall_addr", 64'(imem_addr), 64'h31);
      wait_idle();
      chk("stall_count", 64'(word_count), 64'd2);

      // Address wrap
      begin_session(8'hFF);
      set_desc(9, 3, 4, 0, 16'h1234, 0, 1'b0);
      tick();
      chk("wrap_addr0", 64'(imem_addr), 64'hFF);
      set_desc(10, 5, 6, 0, 16'h00F0, 0, 1'b1);
      tick();
      chk("wrap_addr1", 64'(imem_addr), 64'h00);
      wait_idle();
      chk("wrap_count", 64'(word_count), 64'd2);

      // Illegal mnemonic mid-stream, ignored start during LOAD
      begin_session(8'h40);
      base_addr = 8'h99;
      start = 1'b1;
      tick();
      start = 1'b0;
      set_desc(0, 1, 1, 1, 0, 0, 1'b0);
      tick();
      set_desc(14, 1, 1, 1, 0, 0, 1'b0);
      tick();
      chk("ill_err", 64'(err), 64'd1);
      chk("ill_we",  64'(imem_we), 64'd0);
      set_desc(3, 2, 3, 4, 0, 0, 1'b1);
      tick();
      chk("ill_next_addr", 64'(imem_addr), 64'h41);
      wait_idle();
      chk("ill_err_sticky", 64'(err), 64'd1);
      chk("ill_count", 64'(word_count), 64'd2);
      begin_session(8'h50);
      chk("ill_err_clear", 64'(err), 64'd0);
      set_desc(15, 0, 0, 0, 0, 0, 1'b1);
      tick();
      wait_idle();
      chk("ill_last_count", 64'(word_count), 64'd0);

      // Reset during FLUSH
      begin_session(8'h60);
      imem_ready = 1'b0;
      set_desc(0, 9, 10, 8, 0, 0, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("flush_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_we",    64'(imem_we), 64'd0);
      chk("abort_addr",  64'(imem_addr), 64'd0);
      chk("abort_wdata", 64'(imem_wdata), 64'd0);
      chk("abort_busy",  64'(busy), 64'd0);
      chk("abort_done",  64'(done), 64'd0);
      chk("abort_count", 64'(word_count), 64'd0);
      imem_ready = 1'b1;
      tick();
      tick();

      // Randomized sessions
      for (int s = 0; s < 4; s++) rand_session(25);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
